// File: rtl/addsub_pkg.sv
// Shared opcode encodings and flag bundle for the pipelined add/sub datapath.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit slice of the add/sub datapath; also exposes the carry into
// the slice MSB so the top slice can form signed overflow.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

    // sum = a ^ b ^ carry-in at every bit, so the MSB carry-in falls out here
    assign c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Slice-per-stage pipelined add/sub with valid/ready and global stall.
// Define PIPELINED_ADDSUB_SAT_EN to saturate the result on signed overflow.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic              stall;
    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  b_q  [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic              c_q  [STAGES];

    logic [STAGES-1:0] v_in;
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic              c_in [STAGES];
    logic [WIDTH-1:0]  s_n  [STAGES];
    logic [CHUNK-1:0]  sum  [STAGES];
    logic              cout [STAGES];
    logic              c_msb[STAGES];

    flags_t            flags_n;
    flags_t            flags_q;
    logic [WIDTH-1:0]  res_n;
    logic [WIDTH-1:0]  res_q;

    assign stall    = v_q[LAST] & ~out_ready;
    assign in_ready = ~stall;

    // Stage 0 is fed from the ports, later stages from the previous register
    always_comb begin
        v_in[0] = in_valid;
        a_in[0] = x;
        b_in[0] = (opcode == OP_ADD) ? y : ~y;
        c_in[0] = (opcode == OP_SUB);
        s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = v_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        addsub_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .a       (a_in[k][k*CHUNK +: CHUNK]),
            .b       (b_in[k][k*CHUNK +: CHUNK]),
            .cin     (c_in[k]),
            .sum     (sum[k]),
            .cout    (cout[k]),
            .c_msb_in(c_msb[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_n[k] = s_in[k];
            s_n[k][k*CHUNK +: CHUNK] = sum[k];
        end
    end

    always_comb begin
        flags_n          = '0;
        flags_n.carry    = cout[LAST];
        flags_n.overflow = cout[LAST] ^ c_msb[LAST];
        res_n            = s_n[LAST];
`ifdef PIPELINED_ADDSUB_SAT_EN
        // Overflow implies both operands share x's sign; clamp toward it
        if (flags_n.overflow) begin
            if (a_in[LAST][WIDTH-1])
                res_n = {1'b1, {(WIDTH-1){1'b0}}};
            else
                res_n = {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        flags_n.zero     = (res_n == '0);
        flags_n.negative = res_n[WIDTH-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (!stall) begin
            v_q <= v_in;
            for (int k = 0; k < STAGES; k++) begin
                if (v_in[k]) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    s_q[k] <= s_n[k];
                    c_q[k] <= cout[k];
                end
            end
            if (v_in[LAST]) begin
                res_q   <= res_n;
                flags_q <= flags_n;
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign result    = res_q;
    assign carry_out = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;

endmodule
